// File: rtl/hcp_frame_fifo_if.sv
// Stream bundle between pip, the frame FIFO and the HCP.
// The master side is pip/HCP, which drives the write stream and the ready strobe.
interface hcp_frame_fifo_if #(
  parameter int DATA_WIDTH = 9
);
  logic [DATA_WIDTH-1:0] iv_data;
  logic                  i_data_wr;
  logic [DATA_WIDTH-1:0] ov_data;
  logic                  o_data_wr;
  logic                  i_data_ready;
  logic                  o_frame_avail;

  modport master (
    output iv_data, i_data_wr, i_data_ready,
    input  ov_data, o_data_wr, o_frame_avail
  );

  modport slave (
    input  iv_data, i_data_wr, i_data_ready,
    output ov_data, o_data_wr, o_frame_avail
  );
endinterface

// File: rtl/hcp_frame_fifo.sv
// Store-and-forward frame buffer from pip to the HCP: releases only complete frames.
// Optional feature macro: HFF_DROP_STAT_EN adds the saturating ov_drop_cnt statistic.
module hcp_frame_fifo #(
  parameter int DATA_WIDTH     = 9,
  parameter int ADDR_WIDTH     = 8,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  hcp_frame_fifo_if.slave           bus
`ifdef HFF_DROP_STAT_EN
  ,
  output logic [DROP_CNT_WIDTH-1:0] ov_drop_cnt
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_LVL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  if (DROP_CNT_WIDTH < 1) begin : g_bad_drop_width
    $error("DROP_CNT_WIDTH must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DROP
  } wr_state_t;

  wr_state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
  logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr, commit_ptr;
  logic [ADDR_WIDTH:0]   used;
  logic                  full, is_flag;
  logic                  mem_we, wr_adv, wr_rewind, commit_en, drop_evt;

  logic [DATA_WIDTH-1:0] ram_q;
  logic                  ram_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_take, out_load_ok, ram_move, fetch;
  logic                  out_in_frame, tail_out;
  logic [ADDR_WIDTH:0]   pending;

  assign used    = wr_ptr - rd_ptr;
  assign full    = (used == FULL_LVL);
  assign is_flag = bus.iv_data[DATA_WIDTH-1];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // An overflow rewinds wr_ptr to the last commit so a partial frame vanishes atomically.
  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    wr_adv    = 1'b0;
    wr_rewind = 1'b0;
    commit_en = 1'b0;
    drop_evt  = 1'b0;
    if (bus.i_data_wr) begin
      case (state)
        ST_IDLE: begin
          if (is_flag) begin
            if (full) begin
              wr_rewind = 1'b1;
              drop_evt  = 1'b1;
              state_nxt = ST_DROP;
            end else begin
              mem_we    = 1'b1;
              wr_adv    = 1'b1;
              state_nxt = ST_FILL;
            end
          end
        end
        ST_FILL: begin
          if (full) begin
            wr_rewind = 1'b1;
            drop_evt  = 1'b1;
            state_nxt = is_flag ? ST_IDLE : ST_DROP;
          end else begin
            mem_we = 1'b1;
            wr_adv = 1'b1;
            if (is_flag) begin
              commit_en = 1'b1;
              state_nxt = ST_IDLE;
            end
          end
        end
        ST_DROP: begin
          if (is_flag) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
    end else begin
      if (wr_rewind)   wr_ptr <= commit_ptr;
      else if (wr_adv) wr_ptr <= wr_ptr + PTR_ONE;
      if (commit_en)   commit_ptr <= wr_ptr + PTR_ONE;
    end
  end

  // Two-stage show-ahead: RAM output register, then the visible output register.
  assign out_take    = out_valid & bus.i_data_ready;
  assign out_load_ok = ~out_valid | out_take;
  assign ram_move    = ram_valid & out_load_ok;
  assign fetch       = (commit_ptr != rd_ptr) & (~ram_valid | ram_move);

  always_ff @(posedge i_clk) begin
    if (mem_we) mem[wr_ptr[ADDR_WIDTH-1:0]] <= bus.iv_data;
    if (fetch)  ram_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_ptr    <= '0;
      ram_valid <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (fetch) rd_ptr <= rd_ptr + PTR_ONE;
      ram_valid <= fetch | (ram_valid & ~ram_move);
      if (ram_move) begin
        out_valid <= 1'b1;
        out_data  <= ram_q;
      end else if (out_take) begin
        out_valid <= 1'b0;
        out_data  <= '0;
      end
    end
  end

  // Delimiters alternate head/tail on the output, so every second flagged word is a tail.
  assign tail_out = out_take & out_data[DATA_WIDTH-1] & out_in_frame;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_in_frame <= 1'b0;
      pending      <= '0;
    end else begin
      if (out_take & out_data[DATA_WIDTH-1]) out_in_frame <= ~out_in_frame;
      case ({commit_en, tail_out})
        2'b10:   pending <= pending + PTR_ONE;
        2'b01:   pending <= pending - PTR_ONE;
        default: pending <= pending;
      endcase
    end
  end

  assign bus.ov_data       = out_data;
  assign bus.o_data_wr     = out_valid;
  assign bus.o_frame_avail = (pending != '0);

`ifdef HFF_DROP_STAT_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                          ov_drop_cnt <= '0;
    else if (drop_evt && ~&ov_drop_cnt) ov_drop_cnt <= ov_drop_cnt + 1'b1;
  end
`else
  logic unused_drop_evt;
  assign unused_drop_evt = drop_evt;
`endif

endmodule

// File: tb/tb_hcp_frame_fifo.sv
// Randomized scoreboard bench for hcp_frame_fifo (16-word buffer).
// A frame-level model predicts which frames survive; a monitor checks every transfer.
module tb_hcp_frame_fifo;
  localparam int DW    = 9;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic i_clk = 1'b0;
  logic i_rst;

  hcp_frame_fifo_if #(.DATA_WIDTH(DW)) bus ();

`ifdef HFF_DROP_STAT_EN
  logic [15:0] ov_drop_cnt;
`endif

  hcp_frame_fifo #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DROP_CNT_WIDTH(16)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus(bus)
`ifdef HFF_DROP_STAT_EN
    ,
    .ov_drop_cnt(ov_drop_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [DW-1:0] exp_q[$];
  int model_drops = 0;
  int ready_mode  = 0;
  int pat_idx     = 0;
  bit ready_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  bit stalled_prev = 1'b0;
  logic [DW-1:0] held_val = '0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic report_fail(input string name);
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL %s", name);
  endtask

  // Ready modes: 0 always high, 1 random, 2 fixed pattern, 3 always low.
  initial begin
    bus.i_data_ready = 1'b1;
    forever begin
      @(posedge i_clk);
      #1;
      case (ready_mode)
        0: bus.i_data_ready = 1'b1;
        1: bus.i_data_ready = ($urandom_range(0, 3) != 0);
        2: begin
          bus.i_data_ready = ready_pat[pat_idx];
          pat_idx = (pat_idx + 1) % 6;
        end
        default: bus.i_data_ready = 1'b0;
      endcase
    end
  end

  always @(negedge i_clk) begin
    if (i_rst) begin
      stalled_prev = 1'b0;
    end else if (bus.o_data_wr) begin
      check_output("avail_with_data", 32'(bus.o_frame_avail), 32'd1);
      if (stalled_prev) check_output("hold_data", 32'(bus.ov_data), 32'(held_val));
      if (bus.i_data_ready) begin
        stalled_prev = 1'b0;
        if (exp_q.size() == 0) report_fail("unexpected_word");
        else check_output("data", 32'(bus.ov_data), 32'(exp_q.pop_front()));
      end else begin
        stalled_prev = 1'b1;
        held_val     = bus.ov_data;
      end
    end else begin
      if (stalled_prev) report_fail("valid_dropped_while_stalled");
      stalled_prev = 1'b0;
      check_output("idle_zero", 32'(bus.ov_data), 32'd0);
    end
  end

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic drive_word(input logic [DW-1:0] w);
    bus.iv_data   = w;
    bus.i_data_wr = 1'b1;
    @(posedge i_clk);
    #1;
    bus.i_data_wr = 1'b0;
    bus.iv_data   = '0;
  endtask

  function automatic void build_frame(output logic [DW-1:0] f[$], input int len);
    f.delete();
    f.push_back({1'b1, 8'($urandom)});
    for (int i = 1; i < len - 1; i++) f.push_back({1'b0, 8'($urandom)});
    f.push_back({1'b1, 8'($urandom)});
  endfunction

  // Frames longer than the buffer can never fit; callers guarantee room for shorter ones.
  task automatic apply_stimulus(input logic [DW-1:0] frame[$]);
    if (frame.size() > DEPTH) model_drops++;
    else foreach (frame[i]) exp_q.push_back(frame[i]);
    foreach (frame[i]) drive_word(frame[i]);
  endtask

  task automatic wait_room(input int len);
    int budget = 2000;
    while (exp_q.size() + len > DEPTH && budget > 0) begin
      idle_cycles(1);
      budget--;
    end
    if (budget == 0) report_fail("room_timeout");
  endtask

  task automatic wait_drain(input string name);
    int budget = 3000;
    while (exp_q.size() != 0 && budget > 0) begin
      idle_cycles(1);
      budget--;
    end
    if (budget == 0) report_fail({name, "_drain_timeout"});
    idle_cycles(3);
    check_output({name, "_valid_end"}, 32'(bus.o_data_wr), 32'd0);
    check_output({name, "_avail_end"}, 32'(bus.o_frame_avail), 32'd0);
`ifdef HFF_DROP_STAT_EN
    check_output({name, "_drop_cnt"}, 32'(ov_drop_cnt), 32'(model_drops));
`endif
  endtask

  initial begin
    logic [DW-1:0] f1[$];
    logic [DW-1:0] f2[$];
    logic [DW-1:0] frame_a[$];
    logic [DW-1:0] frame_c[$];
    int len, budget;

    frame_a = '{9'h1A0, 9'h011, 9'h022, 9'h033, 9'h044, 9'h1B0};
    frame_c = '{9'h1C0, 9'h055, 9'h066, 9'h1C1};
    bus.iv_data   = '0;
    bus.i_data_wr = 1'b0;
    i_rst         = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    check_output("rst_valid", 32'(bus.o_data_wr), 32'd0);
    check_output("rst_data", 32'(bus.ov_data), 32'd0);
    check_output("rst_avail", 32'(bus.o_frame_avail), 32'd0);
`ifdef HFF_DROP_STAT_EN
    check_output("rst_drop_cnt", 32'(ov_drop_cnt), 32'd0);
`endif
    i_rst = 1'b0;
    idle_cycles(2);

    // Basic frame with exact head latency after the tail edge.
    ready_mode = 0;
    apply_stimulus(frame_a);
    @(negedge i_clk);
    check_output("lat_edge_k", 32'(bus.o_data_wr), 32'd0);
    check_output("avail_after_commit", 32'(bus.o_frame_avail), 32'd1);
    @(negedge i_clk);
    check_output("lat_edge_k1", 32'(bus.o_data_wr), 32'd0);
    @(negedge i_clk);
    check_output("lat_edge_k2", 32'(bus.o_data_wr), 32'd1);
    check_output("first_word", 32'(bus.ov_data), 32'h1A0);
    @(posedge i_clk);
    #1;
    wait_drain("t1");

    ready_mode = 2;
    pat_idx    = 0;
    apply_stimulus(frame_a);
    wait_drain("t2");
    ready_mode = 0;

    build_frame(f1, 20);
    apply_stimulus(f1);
    apply_stimulus(frame_c);
    wait_drain("t3");

    // Back-to-back frames must stream out without a bubble.
    build_frame(f1, 8);
    build_frame(f2, 8);
    fork
      begin
        apply_stimulus(f1);
        apply_stimulus(f2);
      end
      begin
        budget = 0;
        @(negedge i_clk);
        while (!bus.o_data_wr && budget < 50) begin
          @(negedge i_clk);
          budget++;
        end
        if (budget >= 50) report_fail("contig_start_timeout");
        for (int i = 0; i < 16; i++) begin
          check_output("contig_valid", 32'(bus.o_data_wr), 32'd1);
          @(negedge i_clk);
        end
        check_output("contig_end", 32'(bus.o_data_wr), 32'd0);
      end
    join
    @(posedge i_clk);
    #1;
    wait_drain("t4");

    drive_word(9'h012);
    drive_word(9'h034);
    apply_stimulus(frame_a);
    wait_drain("t5");

    ready_mode = 1;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) drive_word({1'b0, 8'($urandom)});
      end
      len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(17, 22)) : int'($urandom_range(2, 12));
      if (len <= DEPTH) wait_room(len);
      build_frame(f1, len);
      apply_stimulus(f1);
      idle_cycles($urandom_range(0, 3));
    end
    wait_drain("rand");

    // Reset while a frame is stalled on the output and another is half written.
    ready_mode = 3;
    apply_stimulus(frame_c);
    idle_cycles(4);
    check_output("pre_rst_valid", 32'(bus.o_data_wr), 32'd1);
    build_frame(f1, 10);
    for (int i = 0; i < 3; i++) drive_word(f1[i]);
    i_rst = 1'b1;
    #1;
    check_output("mid_rst_valid", 32'(bus.o_data_wr), 32'd0);
    check_output("mid_rst_data", 32'(bus.ov_data), 32'd0);
    check_output("mid_rst_avail", 32'(bus.o_frame_avail), 32'd0);
    exp_q.delete();
    model_drops = 0;
    @(posedge i_clk);
    #1;
    idle_cycles(1);
    i_rst      = 1'b0;
    ready_mode = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      check_output("post_rst_quiet", 32'(bus.o_data_wr), 32'd0);
    end
    @(posedge i_clk);
    #1;
    apply_stimulus(frame_a);
    wait_drain("t6");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
